// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu -- integer execute stage: single-cycle ALU / branch / jump unit
// plus an optional iterative radix-2 multiply/divide unit (M extension).
//
// Handshake (both sides): a transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both high. valid never
// depends on ready. Once o_valid is high, the result outputs hold steady
// until the edge where i_ready is high (or a flush/reset discards them).
//
// Ports
//   i_clk, i_reset          clock (rising edge), async active-low reset
//   i_valid / o_ready       upstream operation handshake
//   i_ALUop, i_func3,       operation class, sub-op, SUB/SRA select,
//   i_func7, i_muldiv       R-type M-op flag
//   i_A, i_B                rs1, rs2
//   i_Imm_SignExt, i_NPC    sign-extended immediate, instruction PC
//   i_flush                 discard in-flight and held operation
//   o_valid / i_ready       downstream result handshake
//   o_ALUOutput             result
//   o_branch, o_jmp,        branch taken, redirect required,
//   o_jmp_pc                redirect target
//   o_dbg_state             FSM state (0 = IDLE, 1 = BUSY)
// ---------------------------------------------------------------------------
module exec_alu #(
  parameter int XLEN      = 32,
  parameter int EN_MULDIV = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_ALUop,
  input  logic [2:0]      i_func3,
  input  logic            i_func7,
  input  logic            i_muldiv,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic [XLEN-1:0] i_Imm_SignExt,
  input  logic [XLEN-1:0] i_NPC,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_ALUOutput,
  output logic            o_branch,
  output logic            o_jmp,
  output logic [XLEN-1:0] o_jmp_pc,
  output logic            o_dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e state_q, state_d;

  logic [SHW-1:0]    cnt_q;
  logic [2*XLEN-1:0] acc_q;     // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opd_q;     // multiplicand or divisor magnitude
  logic [2:0]        md_f3_q;
  logic              md_neg_q;  // final result must be negated

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic md_op, accept, md_start, md_last;

  assign o_ready     = (state_q == IDLE) && (!o_valid || i_ready) && !i_flush;
  assign accept      = i_valid && o_ready;
  assign md_op       = (i_ALUop == 3'd2) && i_muldiv;
  assign md_start    = accept && md_op && (EN_MULDIV != 0);
  assign md_last     = (state_q == BUSY) && (cnt_q == CNT_LAST);
  assign o_dbg_state = (state_q == BUSY);

  // -------------------------------------------------------------------------
  // Single-cycle ALU, branch and jump logic
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] opb, alu_res, jmp_pc_c, npc_imm, a_imm;
  logic [SHW-1:0]  shamt;
  logic            br_c, jmp_c;

  always_comb begin
    opb      = (i_ALUop == 3'd3) ? i_Imm_SignExt : i_B;
    shamt    = opb[SHW-1:0];
    npc_imm  = i_NPC + i_Imm_SignExt;
    a_imm    = i_A + i_Imm_SignExt;
    alu_res  = '0;
    jmp_pc_c = '0;
    br_c     = 1'b0;
    jmp_c    = 1'b0;
    case (i_ALUop)
      3'd0: alu_res = a_imm;
      3'd1: begin
        alu_res  = npc_imm;
        jmp_pc_c = npc_imm;
        case (i_func3)
          3'd0:    br_c = (i_A == i_B);
          3'd1:    br_c = (i_A != i_B);
          3'd4:    br_c = ($signed(i_A) <  $signed(i_B));
          3'd5:    br_c = ($signed(i_A) >= $signed(i_B));
          3'd6:    br_c = (i_A <  i_B);
          3'd7:    br_c = (i_A >= i_B);
          default: br_c = 1'b0;
        endcase
        jmp_c = br_c;
      end
      3'd2, 3'd3: begin
        // M-ops produce 0 here; with the M unit enabled they never use it.
        if (!md_op) begin
          case (i_func3)
            3'd0: alu_res = (i_ALUop == 3'd2 && i_func7) ? (i_A - opb) : (i_A + opb);
            3'd1: alu_res = i_A << shamt;
            3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(i_A) < $signed(opb))};
            3'd3: alu_res = {{(XLEN-1){1'b0}}, (i_A < opb)};
            3'd4: alu_res = i_A ^ opb;
            3'd5: alu_res = i_func7 ? $unsigned($signed(i_A) >>> shamt) : (i_A >> shamt);
            3'd6: alu_res = i_A | opb;
            default: alu_res = i_A & opb;
          endcase
        end
      end
      3'd4: alu_res = i_Imm_SignExt;
      3'd5: alu_res = npc_imm;
      3'd6: begin
        alu_res  = i_NPC + FOUR;
        jmp_c    = 1'b1;
        jmp_pc_c = npc_imm;
      end
      default: begin
        alu_res  = i_NPC + FOUR;
        jmp_c    = 1'b1;
        jmp_pc_c = {a_imm[XLEN-1:1], 1'b0};
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // M-unit operand preparation: work on magnitudes, fix the sign at the end
  // -------------------------------------------------------------------------
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_c;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (i_func3 == 3'd1) || (i_func3 == 3'd2) || (i_func3 == 3'd4) || (i_func3 == 3'd6);
    b_sgn = (i_func3 == 3'd1) || (i_func3 == 3'd4) || (i_func3 == 3'd6);
    a_neg = a_sgn && i_A[XLEN-1];
    b_neg = b_sgn && i_B[XLEN-1];
    a_mag = a_neg ? -i_A : i_A;
    b_mag = b_neg ? -i_B : i_B;
    // Remainder takes the dividend's sign. A zero divisor leaves the quotient
    // magnitude all ones, which must come out unnegated.
    if (i_func3[2]) neg_c = i_func3[1] ? a_neg : ((a_neg ^ b_neg) && (i_B != '0));
    else            neg_c = a_neg ^ b_neg;
  end

  // -------------------------------------------------------------------------
  // One radix-2 step per cycle, and the final result selection
  // -------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   dv_sel, md_res;
  logic              unused_bits;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opd_q} & {(XLEN+1){acc_q[0]}});
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
    div_ge    = ~div_diff[XLEN+1];
    if (md_f3_q[2])
      acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = md_neg_q ? -acc_step : acc_step;
    dv_sel   = md_f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (md_f3_q[2])             md_res = md_neg_q ? -dv_sel : dv_sel;
    else if (md_f3_q == 3'd0)   md_res = prod_fix[XLEN-1:0];
    else                        md_res = prod_fix[2*XLEN-1:XLEN];
  end

  // When a step succeeds the difference is below the divisor, so bit XLEN is zero.
  assign unused_bits = div_diff[XLEN];

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = BUSY;
      BUSY:    if (i_flush || md_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers. Priority: flush, M completion, M step,
  // acceptance, drain.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opd_q       <= '0;
      md_f3_q     <= '0;
      md_neg_q    <= 1'b0;
      o_valid     <= 1'b0;
      o_ALUOutput <= '0;
      o_branch    <= 1'b0;
      o_jmp       <= 1'b0;
      o_jmp_pc    <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      cnt_q   <= '0;
    end else if (md_last) begin
      o_valid     <= 1'b1;
      o_ALUOutput <= md_res;
      o_branch    <= 1'b0;
      o_jmp       <= 1'b0;
      o_jmp_pc    <= '0;
      cnt_q       <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end else if (accept) begin
      if (md_start) begin
        acc_q    <= {{XLEN{1'b0}}, a_mag};
        opd_q    <= b_mag;
        md_f3_q  <= i_func3;
        md_neg_q <= neg_c;
        cnt_q    <= '0;
        o_valid  <= 1'b0;
      end else begin
        o_valid     <= 1'b1;
        o_ALUOutput <= alu_res;
        o_branch    <= br_c;
        o_jmp       <= jmp_c;
        o_jmp_pc    <= jmp_pc_c;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
`timescale 1ns/1ps
module tb_exec_alu;
  localparam int XLEN = 32;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  logic            i_valid, o_ready, i_func7, i_muldiv, i_flush, o_valid, i_ready;
  logic [2:0]      i_ALUop, i_func3;
  logic [XLEN-1:0] i_A, i_B, i_Imm_SignExt, i_NPC, o_ALUOutput, o_jmp_pc;
  logic            o_branch, o_jmp, o_dbg_state;

  exec_alu #(.XLEN(XLEN), .EN_MULDIV(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_ALUop(i_ALUop), .i_func3(i_func3), .i_func7(i_func7), .i_muldiv(i_muldiv),
    .i_A(i_A), .i_B(i_B), .i_Imm_SignExt(i_Imm_SignExt), .i_NPC(i_NPC),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_ALUOutput(o_ALUOutput), .o_branch(o_branch), .o_jmp(o_jmp),
    .o_jmp_pc(o_jmp_pc), .o_dbg_state(o_dbg_state)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        md;
    logic [31:0] a, b, imm, npc;
    logic [31:0] res;
    logic        br, jmp, chk_pc;
    logic [31:0] pc;
  } vec_t;

  // scoreboard entry: {res, br, jmp, chk_pc, pc}
  logic [66:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int n_out = 0;

  function automatic vec_t v(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic [31:0] npc, input logic [31:0] res, input logic br,
                             input logic jmp, input logic chk_pc, input logic [31:0] pc);
    vec_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.md = 1'b0; r.a = a; r.b = b; r.imm = imm; r.npc = npc;
    r.res = res; r.br = br; r.jmp = jmp; r.chk_pc = chk_pc; r.pc = pc;
    return r;
  endfunction

  // Reference for the M-ops, computed with 64-bit arithmetic.
  function automatic logic [31:0] m_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic vec_t mv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    r = v(3'd2, f3, 1'b0, a, b, 32'd0, 32'd0, m_model(f3, a, b), 1'b0, 1'b0, 1'b0, 32'd0);
    r.md = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // driver: present op, wait (bounded) for o_ready, push expectation, accept
  task automatic issue(input vec_t t, input bit push);
    bit done;
    done = 1'b0;
    i_ALUop = t.op; i_func3 = t.f3; i_func7 = t.f7; i_muldiv = t.md;
    i_A = t.a; i_B = t.b; i_Imm_SignExt = t.imm; i_NPC = t.npc;
    i_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (o_ready) begin
        if (push) exp_q.push_back({t.res, t.br, t.jmp, t.chk_pc, t.pc});
        done = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL issue_timeout op=%0d f3=%0d", t.op, t.f3);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(posedge i_clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    logic [66:0] e;
    if (i_reset && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h", o_ALUOutput);
      end else begin
        e = exp_q.pop_front();
        if (o_ALUOutput !== e[66:35] || o_branch !== e[34] || o_jmp !== e[33] ||
            (e[32] && o_jmp_pc !== e[31:0])) begin
          failures++;
          $display("FAIL out%0d got res=%h br=%b jmp=%b pc=%h exp res=%h br=%b jmp=%b pc=%h",
                   n_out, o_ALUOutput, o_branch, o_jmp, o_jmp_pc, e[66:35], e[34], e[33], e[31:0]);
        end
      end
      n_out++;
    end
  end

  vec_t tbl[$];
  vec_t t;
  int   cnt;
  bit   got;

  initial begin
    i_valid = 0; i_ALUop = 0; i_func3 = 0; i_func7 = 0; i_muldiv = 0;
    i_A = 0; i_B = 0; i_Imm_SignExt = 0; i_NPC = 0; i_flush = 0; i_ready = 1;

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_res", o_ALUOutput, 0);
    chk("rst_branch", o_branch, 0);
    chk("rst_jmp", o_jmp, 0);
    chk("rst_jmp_pc", o_jmp_pc, 0);
    chk("rst_state", o_dbg_state, 0);
    chk("rst_ready", o_ready, 1);

    //           op  f3  f7  a             b             imm           npc        res           br jmp chk pc
    tbl.push_back(v(2, 0, 0, 32'd5,        32'd7,        0,            0,         32'd12,        0, 0, 0, 0));
    tbl.push_back(v(2, 0, 1, 32'd5,        32'd7,        0,            0,         32'hFFFFFFFE,  0, 0, 0, 0));
    tbl.push_back(v(2, 1, 0, 32'd1,        32'h24,       0,            0,         32'h10,        0, 0, 0, 0));
    tbl.push_back(v(2, 2, 0, 32'hFFFFFFFF, 32'd1,        0,            0,         32'd1,         0, 0, 0, 0));
    tbl.push_back(v(2, 3, 0, 32'd1,        32'hFFFFFFFF, 0,            0,         32'd1,         0, 0, 0, 0));
    tbl.push_back(v(2, 4, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0,            0,         32'hFF00FF00,  0, 0, 0, 0));
    tbl.push_back(v(2, 5, 0, 32'h80000000, 32'd33,       0,            0,         32'h40000000,  0, 0, 0, 0));
    tbl.push_back(v(2, 5, 1, 32'h80000000, 32'd33,       0,            0,         32'hC0000000,  0, 0, 0, 0));
    tbl.push_back(v(2, 6, 0, 32'h00FF0000, 32'h0000FF00, 0,            0,         32'h00FFFF00,  0, 0, 0, 0));
    tbl.push_back(v(2, 7, 0, 32'hFFFF0000, 32'h0FF00FF0, 0,            0,         32'h0FF00000,  0, 0, 0, 0));
    tbl.push_back(v(3, 0, 1, 32'd10,       0,            32'hFFFFFFFD, 0,         32'd7,         0, 0, 0, 0));
    tbl.push_back(v(3, 2, 0, 32'hFFFFFFFB, 0,            32'hFFFFFFFC, 0,         32'd1,         0, 0, 0, 0));
    tbl.push_back(v(3, 3, 0, 32'd5,        0,            32'hFFFFFFFC, 0,         32'd1,         0, 0, 0, 0));
    tbl.push_back(v(3, 5, 1, 32'hF0000000, 0,            32'd4,        0,         32'hFF000000,  0, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 32'd3,        0,            32'd31,       0,         32'h80000000,  0, 0, 0, 0));
    tbl.push_back(v(3, 7, 0, 32'h12345678, 0,            32'hFF,       0,         32'h78,        0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 32'h1000,     0,            32'hFFFFFFFC, 0,         32'hFFC,       0, 0, 0, 0));
    tbl.push_back(v(4, 0, 0, 0,            0,            32'h12345000, 0,         32'h12345000,  0, 0, 0, 0));
    tbl.push_back(v(5, 0, 0, 0,            0,            32'h2000,     32'h100,   32'h2100,      0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 32'd5,        32'd5,        32'h10,       32'h200,   32'h210,       1, 1, 1, 32'h210));
    tbl.push_back(v(1, 1, 0, 32'd5,        32'd5,        32'h10,       32'h200,   32'h210,       0, 0, 1, 32'h210));
    tbl.push_back(v(1, 4, 0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFF8, 32'h100,   32'hF8,        1, 1, 1, 32'hF8));
    tbl.push_back(v(1, 5, 0, 32'hFFFFFFFF, 32'd0,        32'd8,        32'h100,   32'h108,       0, 0, 1, 32'h108));
    tbl.push_back(v(1, 6, 0, 32'd1,        32'hFFFFFFFF, 32'd4,        32'h300,   32'h304,       1, 1, 1, 32'h304));
    tbl.push_back(v(1, 7, 0, 32'd1,        32'hFFFFFFFF, 32'd4,        32'h300,   32'h304,       0, 0, 1, 32'h304));
    tbl.push_back(v(1, 2, 0, 32'd5,        32'd5,        32'd4,        32'h300,   32'h304,       0, 0, 1, 32'h304));
    tbl.push_back(v(6, 0, 0, 0,            0,            32'h20,       32'h400,   32'h404,       0, 1, 1, 32'h420));
    tbl.push_back(v(7, 0, 0, 32'h1001,     0,            32'd2,        32'h500,   32'h504,       0, 1, 1, 32'h1002));
    tbl.push_back(v(7, 0, 0, 32'h1000,     0,            32'd1,        32'h0,     32'h4,         0, 1, 1, 32'h1000));

    // release reset away from the edge; first op accepted on the next edge
    @(negedge i_clk);
    i_reset = 1'b1;
    foreach (tbl[k]) issue(tbl[k], 1'b1);
    wait_drain(50);

    // backpressure: result held 3 cycles, then a new op goes straight in
    i_ready = 1'b0;
    issue(v(2, 0, 0, 32'd100, 32'd23, 0, 0, 32'd123, 0, 0, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("bp_valid", o_valid, 1);
      chk("bp_res", o_ALUOutput, 32'd123);
      chk("bp_ready", o_ready, 0);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    issue(v(2, 0, 1, 32'd50, 32'd8, 0, 0, 32'd42, 0, 0, 0, 0), 1'b1);
    @(negedge i_clk);
    chk("bp_next_valid", o_valid, 1);
    wait_drain(20);

    // DIV latency and busy length
    issue(mv(3'd4, 32'hFFFFFFF9, 32'd2), 1'b1);
    cnt = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge i_clk);
      if (o_valid) got = 1'b1;
      else if (!o_ready) cnt++;
    end
    chk("div_done", got, 1);
    chk("div_busy_cycles", cnt, 32);
    chk("div_res", o_ALUOutput, 32'hFFFFFFFD);
    wait_drain(50);

    // M corner cases and random M-ops
    issue(mv(3'd5, 32'd9, 32'd0), 1'b1);
    issue(mv(3'd4, 32'd9, 32'd0), 1'b1);
    issue(mv(3'd6, 32'hFFFFFFF7, 32'd0), 1'b1);
    issue(mv(3'd6, 32'h80000000, 32'hFFFFFFFF), 1'b1);
    issue(mv(3'd4, 32'h80000000, 32'hFFFFFFFF), 1'b1);
    issue(mv(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1);
    issue(mv(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1);
    issue(mv(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1);
    issue(mv(3'd0, 32'h12345678, 32'h9ABCDEF0), 1'b1);
    issue(mv(3'd7, 32'd100, 32'd7), 1'b1);
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 9);
        1:       rb = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: rb = $urandom();
      endcase
      issue(mv(3'($urandom_range(0, 7)), ra, rb), 1'b1);
    end
    wait_drain(100);

    // flush in BUSY cycle 10: no result, back to IDLE
    issue(mv(3'd4, 32'd1000, 32'd3), 1'b0);
    repeat (10) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    #1;
    chk("flush_ready_low", o_ready, 0);
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    #1;
    chk("flush_state", o_dbg_state, 0);
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (o_valid) cnt++;
    end
    chk("flush_no_result", cnt, 0);

    // reset mid-DIV: aborts, outputs cleared, restart accepts on first edge
    issue(mv(3'd4, 32'd77, 32'd5), 1'b0);
    repeat (5) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mid_rst_state", o_dbg_state, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_res", o_ALUOutput, 0);
    chk("mid_rst_branch", o_branch, 0);
    chk("mid_rst_jmp", o_jmp, 0);
    chk("mid_rst_jmp_pc", o_jmp_pc, 0);
    chk("mid_rst_ready", o_ready, 1);
    @(negedge i_clk);
    i_reset = 1'b1;
    issue(v(2, 0, 0, 32'd1, 32'd2, 0, 0, 32'd3, 0, 0, 0, 0), 1'b1);
    @(negedge i_clk);
    chk("post_rst_first", o_valid, 1);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
